// File: rtl/key_pkg.sv
// key_pkg: shared key indices, default timing and repeat-state encoding
package key_pkg;
  localparam int KEY_LEFT    = 0;
  localparam int KEY_RIGHT   = 1;
  localparam int KEY_UP      = 2;
  localparam int KEY_DOWN    = 3;
  localparam int KEY_RESTART = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 15_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;
endpackage

// File: rtl/key_channel.sv
// key_channel: one key's synchroniser, debouncer, edge pulses and auto-repeat
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic s1, s2, stable;
  logic [DW-1:0] dcnt;
  logic flip, rise, fall;
  rep_state_t state, state_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic rpt_d, dly_due, per_due;
  assign flip      = (s2 != stable) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign rise      = flip & ~stable;
  assign fall      = flip & stable;
  assign key_level = stable;
  assign dly_due   = rcnt == RW'(REPEAT_DELAY - 1);
  assign per_due   = rcnt == RW'(REPEAT_PERIOD - 1);
  // synchronise, debounce and register the edge pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      stable      <= 1'b0;
      dcnt        <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_in ^ ACTIVE_LOW;
      s2          <= s1;
      stable      <= stable ^ flip;
      dcnt        <= (s2 == stable || flip) ? '0 : dcnt + DW'(1);
      key_press   <= rise;
      key_release <= fall;
    end
  // repeat state, counter and registered repeat pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      rcnt       <= '0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_d;
      rcnt       <= rcnt_d;
      key_repeat <= rpt_d;
    end
  // next state: a release always wins over a due repeat
  always_comb begin
    state_d = state;
    rcnt_d  = '0;
    case (state)
      IDLE:   state_d = (rise && REPEAT_EN) ? DELAY : IDLE;
      DELAY: begin
        state_d = fall ? IDLE : dly_due ? REPEAT : DELAY;
        rcnt_d  = (fall || dly_due) ? '0 : rcnt + RW'(1);
      end
      REPEAT: begin
        state_d = fall ? IDLE : REPEAT;
        rcnt_d  = (fall || per_due) ? '0 : rcnt + RW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // repeat pulse on press, then on each due interval unless released
  always_comb
    rpt_d = (state == IDLE && rise) ||
            (state == DELAY && dly_due && !fall) ||
            (state == REPEAT && per_due && !fall);
endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: conditions raw pushbuttons into clean level and pulse events
module key_conditioner
  import key_pkg::*;
#(
  parameter int                N_KEYS          = 5,
  parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = 5'b01111,
  parameter bit                KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (REPEAT_MASK[i]),
      .ACTIVE_LOW     (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk        (CLOCK_50),
      .rst_n      (reset),
      .key_in     (key_in[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i])
    );
  end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce, edge pulses and auto-repeat
module tb_key_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] key_in = 5'h1F;
  logic [4:0] key_level, key_press, key_release, key_repeat;
  int checks = 0;
  int errs = 0;

  key_conditioner #(
    .N_KEYS(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
    .REPEAT_MASK(5'b01111), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_50(clk), .reset(rst_n), .key_in(key_in), .key_level(key_level),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    key_in = 5'h1F;
    repeat (3) @(negedge clk);
    checks++; if (key_level !== 5'b0) begin errs++; $display("FAIL reset_level got %b want %b", key_level, 5'b0); end
    checks++; if (key_press !== 5'b0) begin errs++; $display("FAIL reset_press got %b want %b", key_press, 5'b0); end
    checks++; if (key_release !== 5'b0) begin errs++; $display("FAIL reset_release got %b want %b", key_release, 5'b0); end
    checks++; if (key_repeat !== 5'b0) begin errs++; $display("FAIL reset_repeat got %b want %b", key_repeat, 5'b0); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_clean_press;
    logic [4:0] e;
    key_in[0] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b00001 : 5'b00000;
      checks++; if (key_press !== e) begin errs++; $display("FAIL clean_press n=%0d got %b want %b", n, key_press, e); end
      checks++; if (key_repeat !== e) begin errs++; $display("FAIL clean_repeat n=%0d got %b want %b", n, key_repeat, e); end
      e = (n >= 6) ? 5'b00001 : 5'b00000;
      checks++; if (key_level !== e) begin errs++; $display("FAIL clean_level n=%0d got %b want %b", n, key_level, e); end
    end
    key_in[0] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b00001 : 5'b00000;
      checks++; if (key_release !== e) begin errs++; $display("FAIL clean_release n=%0d got %b want %b", n, key_release, e); end
      checks++; if (key_repeat !== 5'b0) begin errs++; $display("FAIL clean_norepeat n=%0d got %b want %b", n, key_repeat, 5'b0); end
    end
    idle(4);
  endtask

  task automatic test_bounce;
    logic [4:0] e;
    key_in[1] = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++; if (key_press !== 5'b0) begin errs++; $display("FAIL bounce_low n=%0d got %b want %b", n, key_press, 5'b0); end
    end
    key_in[1] = 1'b1;
    @(negedge clk);
    checks++; if (key_press !== 5'b0) begin errs++; $display("FAIL bounce_high got %b want %b", key_press, 5'b0); end
    key_in[1] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b00010 : 5'b00000;
      checks++; if (key_press !== e) begin errs++; $display("FAIL bounce_press n=%0d got %b want %b", n, key_press, e); end
    end
    key_in[1] = 1'b1;
    idle(10);
  endtask

  task automatic test_autorepeat;
    logic e;
    key_in[2] = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      @(negedge clk);
      e = (n == 6) || (n >= 16 && n < 43 && (n - 16) % 3 == 0);
      checks++; if (key_repeat[2] !== e) begin errs++; $display("FAIL auto_repeat n=%0d got %b want %b", n, key_repeat[2], e); end
      e = (n == 43);
      checks++; if (key_release[2] !== e) begin errs++; $display("FAIL auto_release n=%0d got %b want %b", n, key_release[2], e); end
      if (n == 37) key_in[2] = 1'b1;
    end
    idle(4);
  endtask

  task automatic test_masked;
    logic e;
    key_in[4] = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      e = (n == 6);
      checks++; if (key_repeat[4] !== e) begin errs++; $display("FAIL masked_repeat n=%0d got %b want %b", n, key_repeat[4], e); end
      checks++; if (key_press[4] !== e) begin errs++; $display("FAIL masked_press n=%0d got %b want %b", n, key_press[4], e); end
    end
    key_in[4] = 1'b1;
    idle(10);
  endtask

  task automatic test_simultaneous;
    logic [4:0] e;
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b01001 : 5'b00000;
      checks++; if (key_press !== e) begin errs++; $display("FAIL simul_press n=%0d got %b want %b", n, key_press, e); end
    end
    key_in[0] = 1'b1;
    key_in[3] = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b01001 : 5'b00000;
      checks++; if (key_release !== e) begin errs++; $display("FAIL simul_release n=%0d got %b want %b", n, key_release, e); end
    end
    idle(4);
  endtask

  task automatic test_reset_mid;
    logic [4:0] e;
    key_in[2] = 1'b0;
    repeat (18) @(negedge clk);
    checks++; if (key_level !== 5'b00100) begin errs++; $display("FAIL mid_level_before got %b want %b", key_level, 5'b00100); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key_level !== 5'b0) begin errs++; $display("FAIL mid_level got %b want %b", key_level, 5'b0); end
    checks++; if (key_press !== 5'b0) begin errs++; $display("FAIL mid_press got %b want %b", key_press, 5'b0); end
    checks++; if (key_release !== 5'b0) begin errs++; $display("FAIL mid_release got %b want %b", key_release, 5'b0); end
    checks++; if (key_repeat !== 5'b0) begin errs++; $display("FAIL mid_repeat got %b want %b", key_repeat, 5'b0); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      e = (n == 6) ? 5'b00100 : 5'b00000;
      checks++; if (key_press !== e) begin errs++; $display("FAIL mid_repress n=%0d got %b want %b", n, key_press, e); end
      checks++; if (key_repeat !== e) begin errs++; $display("FAIL mid_rerepeat n=%0d got %b want %b", n, key_repeat, e); end
    end
    key_in[2] = 1'b1;
    idle(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_masked();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
